// File: rtl/patch_addr_gen_pkg.sv
// Shared types for the patch address generator: FSM encoding and the
// coordinate clamp helper used for both rows and lane columns.
package patch_addr_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, RUN, FIN} state_t;

  typedef struct packed {
    logic [31:0] val;
    logic        oob;
  } clamp_t;

  // Clamp a signed coordinate into [0, hi]; oob marks that clamping happened.
  function automatic clamp_t clamp_coord(input int v, input int hi);
    clamp_t res;
    res.oob = 1'b1;
    if (v < 0) begin
      res.val = '0;
    end else if (v > hi) begin
      res.val = hi;
    end else begin
      res.val = v;
      res.oob = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/patch_addr_gen_if.sv
// Address beat stream from the patch generator to the image-memory read port.
interface patch_addr_gen_if #(
  parameter int LANES = 1,
  parameter int AW    = 20
);
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*AW-1:0]   out_addr;
  logic [LANES-1:0]      out_mask;
  logic [LANES-1:0]      out_oob;
  logic                  out_eol;
  logic                  out_last;

  modport master (output out_valid, out_addr, out_mask, out_oob, out_eol, out_last,
                  input  out_ready);
  modport slave  (input  out_valid, out_addr, out_mask, out_oob, out_eol, out_last,
                  output out_ready);
endinterface

// File: rtl/patch_lane_calc.sv
// Per-lane column clamp, out-of-bounds flag, mask and final address.
module patch_lane_calc
  import patch_addr_pkg::*;
#(
  parameter int LANE = 0,
  parameter int PW   = 14,
  parameter int DW   = 11,
  parameter int AW   = 20
) (
  input  logic signed [PW-1:0] c,
  input  logic signed [PW-1:0] c_end,
  input  logic        [DW-1:0] img_cols,
  input  logic        [AW-1:0] row_base,
  input  logic                 row_oob,
  output logic        [AW-1:0] addr,
  output logic                 oob,
  output logic                 mask
);

  logic signed [PW-1:0] ci;
  clamp_t               cl;

  always_comb begin
    ci   = c + PW'(LANE);
    cl   = clamp_coord(int'(ci), int'(img_cols) - 1);
    mask = (ci <= c_end);
    addr = mask ? (row_base + AW'(cl.val)) : '0;
    oob  = mask & (row_oob | cl.oob);
  end

endmodule

// File: rtl/patch_addr_gen.sv
// Patch address generator: raster-order window addresses around a feature
// point, border-clamped, LANES columns per beat, valid/ready output stream.
module patch_addr_gen
  import patch_addr_pkg::*;
#(
  parameter int MAX_DIM  = 1024,
  parameter int MAX_HALF = 35,
  parameter int LANES    = 1,
  parameter int EXT      = 1,
  parameter int DW       = $clog2(MAX_DIM) + 1,
  parameter int CW       = $clog2(MAX_DIM) + 2,
  parameter int AW       = $clog2(MAX_DIM * MAX_DIM)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [DW-1:0]                   img_rows,
  input  logic [DW-1:0]                   img_cols,
  input  logic [AW-1:0]                   base_addr,
  input  logic signed [CW-1:0]            ctr_row,
  input  logic signed [CW-1:0]            ctr_col,
  input  logic [$clog2(MAX_HALF+1)-1:0]   half_r,
  input  logic [$clog2(MAX_HALF+1)-1:0]   half_c,
  output logic                            busy,
  output logic                            done,
  output logic                            cfg_err,
  patch_addr_gen_if.master                out_if
);

  localparam int HW = $clog2(MAX_HALF + 1);
  localparam int PW = CW + 2;

  state_t               state;
  logic [DW-1:0]        rows_q, cols_q;
  logic [AW-1:0]        base_q, rowacc_q;
  logic signed [CW-1:0] ctr_r_q, ctr_c_q;
  logic [HW-1:0]        hr_q, hc_q;
  logic signed [PW-1:0] r_q, c_q, c0_q, c_end_q, r_end_q, r_next;
  logic                 valid_q;

  int                   r0_i, c0_i;
  clamp_t               row_cl;
  logic                 row_oob, step_add, eol, last, cfg_bad;
  logic [AW-1:0]        row_init, row_base;
  logic [LANES*AW-1:0]  lane_addr;
  logic [LANES-1:0]     lane_oob, lane_mask;

  always_comb begin
    r0_i     = int'(ctr_r_q) - int'(hr_q);
    c0_i     = int'(ctr_c_q) - int'(hc_q);
    // One row clamp serves both phases: start row in SETUP, current row in RUN.
    row_cl   = clamp_coord((state == SETUP) ? r0_i : int'(r_q), int'(rows_q) - 1);
    row_oob  = row_cl.oob;
    row_init = AW'(int'(row_cl.val) * int'(cols_q));
    row_base = base_q + rowacc_q;
    r_next   = r_q + PW'(1);
    step_add = (int'(r_next) >= 1) && (int'(r_next) <= int'(rows_q) - 1);
    eol      = (c_q + PW'(LANES)) > c_end_q;
    last     = eol && (r_q == r_end_q);
    cfg_bad  = (int'(hr_q) > MAX_HALF) || (int'(hc_q) > MAX_HALF) ||
               (rows_q == '0) || (cols_q == '0) ||
               (int'(rows_q) > MAX_DIM) || (int'(cols_q) > MAX_DIM);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    patch_lane_calc #(.LANE(i), .PW(PW), .DW(DW), .AW(AW)) u_lane (
      .c        (c_q),
      .c_end    (c_end_q),
      .img_cols (cols_q),
      .row_base (row_base),
      .row_oob  (row_oob),
      .addr     (lane_addr[i*AW +: AW]),
      .oob      (lane_oob[i]),
      .mask     (lane_mask[i])
    );
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_addr  = valid_q ? lane_addr : '0;
  assign out_if.out_mask  = valid_q ? lane_mask : '0;
  assign out_if.out_oob   = valid_q ? lane_oob  : '0;
  assign out_if.out_eol   = valid_q & eol;
  assign out_if.out_last  = valid_q & last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      valid_q  <= 1'b0;
      rows_q   <= '0;
      cols_q   <= '0;
      base_q   <= '0;
      ctr_r_q  <= '0;
      ctr_c_q  <= '0;
      hr_q     <= '0;
      hc_q     <= '0;
      r_q      <= '0;
      c_q      <= '0;
      c0_q     <= '0;
      c_end_q  <= '0;
      r_end_q  <= '0;
      rowacc_q <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rows_q  <= img_rows;
          cols_q  <= img_cols;
          base_q  <= base_addr;
          ctr_r_q <= ctr_row;
          ctr_c_q <= ctr_col;
          hr_q    <= half_r;
          hc_q    <= half_c;
          busy    <= 1'b1;
          state   <= SETUP;
        end
        SETUP: if (cfg_bad) begin
          done    <= 1'b1;
          cfg_err <= 1'b1;
          busy    <= 1'b0;
          state   <= FIN;
        end else begin
          r_q      <= PW'(r0_i);
          c_q      <= PW'(c0_i);
          c0_q     <= PW'(c0_i);
          c_end_q  <= PW'(int'(ctr_c_q) + int'(hc_q) + EXT);
          r_end_q  <= PW'(int'(ctr_r_q) + int'(hr_q) + EXT);
          rowacc_q <= row_init;
          valid_q  <= 1'b1;
          state    <= RUN;
        end
        RUN: if (valid_q && out_if.out_ready) begin
          if (last) begin
            valid_q <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= FIN;
          end else if (eol) begin
            // Row component only advances while the new row is inside the image.
            r_q <= r_next;
            c_q <= c0_q;
            if (step_add) rowacc_q <= rowacc_q + AW'(cols_q);
          end else begin
            c_q <= c_q + PW'(LANES);
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_patch_addr_gen.sv
// Directed bench for patch_addr_gen: three instances cover LANES=1/EXT=0,
// LANES=4/EXT=1 and LANES=4/EXT=0 windows.
module tb_patch_addr_gen;

  logic               clk = 1'b0;
  logic               reset;
  logic               start_a, start_b, start_c;
  logic [10:0]        img_rows, img_cols;
  logic [19:0]        base_addr;
  logic signed [11:0] ctr_row, ctr_col;
  logic [5:0]         half_r, half_c;
  logic               ready;
  logic               busy_a, done_a, err_a, busy_b, done_b, err_b, busy_c, done_c, err_c;

  int                 sel;
  logic               obs_valid, obs_eol, obs_last, obs_busy, obs_done, obs_err;
  logic [79:0]        obs_addr;
  logic [3:0]         obs_mask, obs_oob;

  logic [79:0]        g_addr [32];
  logic [3:0]         g_mask [32];
  logic [3:0]         g_oob  [32];
  logic               g_eol  [32];
  logic               g_last [32];
  int                 nb, first_cyc, last_cyc, done_cyc;
  int                 tests = 0, failed = 0;

  patch_addr_gen_if #(.LANES(1), .AW(20)) if_a ();
  patch_addr_gen_if #(.LANES(4), .AW(20)) if_b ();
  patch_addr_gen_if #(.LANES(4), .AW(20)) if_c ();

  assign if_a.out_ready = ready;
  assign if_b.out_ready = ready;
  assign if_c.out_ready = ready;

  patch_addr_gen #(.LANES(1), .EXT(0)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .img_rows(img_rows), .img_cols(img_cols),
    .base_addr(base_addr), .ctr_row(ctr_row), .ctr_col(ctr_col), .half_r(half_r),
    .half_c(half_c), .busy(busy_a), .done(done_a), .cfg_err(err_a), .out_if(if_a.master));

  patch_addr_gen #(.LANES(4), .EXT(1)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .img_rows(img_rows), .img_cols(img_cols),
    .base_addr(base_addr), .ctr_row(ctr_row), .ctr_col(ctr_col), .half_r(half_r),
    .half_c(half_c), .busy(busy_b), .done(done_b), .cfg_err(err_b), .out_if(if_b.master));

  patch_addr_gen #(.LANES(4), .EXT(0)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .img_rows(img_rows), .img_cols(img_cols),
    .base_addr(base_addr), .ctr_row(ctr_row), .ctr_col(ctr_col), .half_r(half_r),
    .half_c(half_c), .busy(busy_c), .done(done_c), .cfg_err(err_c), .out_if(if_c.master));

  always #5 clk = ~clk;

  always_comb begin
    obs_valid = 1'b0; obs_eol = 1'b0; obs_last = 1'b0;
    obs_busy  = 1'b0; obs_done = 1'b0; obs_err = 1'b0;
    obs_addr  = '0;   obs_mask = '0;  obs_oob = '0;
    case (sel)
      0: begin
        obs_valid = if_a.out_valid; obs_eol = if_a.out_eol; obs_last = if_a.out_last;
        obs_addr = 80'(if_a.out_addr); obs_mask = 4'(if_a.out_mask); obs_oob = 4'(if_a.out_oob);
        obs_busy = busy_a; obs_done = done_a; obs_err = err_a;
      end
      1: begin
        obs_valid = if_b.out_valid; obs_eol = if_b.out_eol; obs_last = if_b.out_last;
        obs_addr = if_b.out_addr; obs_mask = if_b.out_mask; obs_oob = if_b.out_oob;
        obs_busy = busy_b; obs_done = done_b; obs_err = err_b;
      end
      2: begin
        obs_valid = if_c.out_valid; obs_eol = if_c.out_eol; obs_last = if_c.out_last;
        obs_addr = if_c.out_addr; obs_mask = if_c.out_mask; obs_oob = if_c.out_oob;
        obs_busy = busy_c; obs_done = done_c; obs_err = err_c;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic set_cfg(input int rows, input int cols, input int base,
                         input int cr, input int cc, input int hr, input int hc);
    img_rows = 11'(rows); img_cols = 11'(cols); base_addr = 20'(base);
    ctr_row = 12'(cr); ctr_col = 12'(cc); half_r = 6'(hr); half_c = 6'(hc);
  endtask

  // Pulse start into instance `which`; afterwards the config inputs are scrambled.
  task automatic do_start(input int which);
    sel = which;
    @(posedge clk); #1;
    start_a = (which == 0); start_b = (which == 1); start_c = (which == 2);
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    set_cfg(3, 3, 555, -5, 100, 3, 3);
    check("busy_t1", 96'(obs_busy), 96'(1));
    check("valid_t1", 96'(obs_valid), 96'(0));
  endtask

  task automatic collect(input bit rnd, input int budget);
    logic        stalled;
    logic [89:0] snap;
    nb = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; stalled = 1'b0; snap = '0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(posedge clk); #1;
      if (stalled) begin
        check("hold_valid", 96'(obs_valid), 96'(1));
        check("hold_data", 96'({obs_addr, obs_mask, obs_oob, obs_eol, obs_last}), 96'(snap));
      end
      if (obs_done) begin
        done_cyc = cyc;
        break;
      end
      if (obs_valid && first_cyc < 0) first_cyc = cyc;
      ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 1'b0;
      if (obs_valid) begin
        if (ready) begin
          if (nb < 32) begin
            g_addr[nb] = obs_addr; g_mask[nb] = obs_mask; g_oob[nb] = obs_oob;
            g_eol[nb] = obs_eol; g_last[nb] = obs_last;
          end
          if (obs_last) last_cyc = cyc;
          nb++;
        end else begin
          stalled = 1'b1;
          snap = {obs_addr, obs_mask, obs_oob, obs_eol, obs_last};
        end
      end
    end
    ready = 1'b1;
    check("done_seen", 96'(done_cyc >= 0), 96'(1));
  endtask

  task automatic check_basic_seq(input string tag);
    int exp_addr [9];
    exp_addr = '{34, 35, 36, 44, 45, 46, 54, 55, 56};
    check({tag, "_nbeats"}, 96'(nb), 96'(9));
    for (int i = 0; i < 9 && i < nb; i++) begin
      check({tag, "_addr"}, 96'(g_addr[i]), 96'(exp_addr[i]));
      check({tag, "_eol"},  96'(g_eol[i]),  96'(i % 3 == 2));
      check({tag, "_last"}, 96'(g_last[i]), 96'(i == 8));
      check({tag, "_mask_oob"}, 96'({g_mask[i], g_oob[i]}), 96'(8'h10));
    end
  endtask

  initial begin
    int cn_addr [9];
    int cn_oob  [9];
    cn_addr = '{0, 0, 1, 0, 0, 1, 10, 10, 11};
    cn_oob  = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
    reset = 1'b1; ready = 1'b1; sel = 0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    set_cfg(8, 10, 0, 4, 5, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 96'({obs_valid, obs_eol, obs_last, obs_busy, obs_done, obs_err,
                            obs_mask, obs_oob, obs_addr}), 96'(0));
    reset = 1'b0;

    // Basic 3x3 window
    set_cfg(8, 10, 0, 4, 5, 1, 1);
    do_start(0);
    collect(1'b0, 100);
    check_basic_seq("basic");
    check("first_valid_t2", 96'(first_cyc), 96'(0));
    check("done_after_last", 96'(done_cyc), 96'(last_cyc + 1));
    check("done_state", 96'({obs_busy, obs_valid, obs_err}), 96'(0));
    @(posedge clk); #1;
    check("done_one_cycle", 96'(obs_done), 96'(0));

    // Top-left corner clamp
    set_cfg(8, 10, 0, 0, 0, 1, 1);
    do_start(0);
    collect(1'b0, 100);
    check("corner_nbeats", 96'(nb), 96'(9));
    for (int i = 0; i < 9 && i < nb; i++) begin
      check("corner_addr", 96'(g_addr[i]), 96'(cn_addr[i]));
      check("corner_oob",  96'(g_oob[i]),  96'(cn_oob[i]));
    end

    // Four lanes with bilinear extension: 4x4 window, one beat per row
    set_cfg(8, 10, 100, 4, 5, 1, 1);
    do_start(1);
    collect(1'b0, 100);
    check("wide_nbeats", 96'(nb), 96'(4));
    for (int i = 0; i < 4 && i < nb; i++) begin
      int a;
      a = 100 + (3 + i) * 10 + 4;
      check("wide_addr", 96'(g_addr[i]), 96'({20'(a + 3), 20'(a + 2), 20'(a + 1), 20'(a)}));
      check("wide_mask_oob", 96'({g_mask[i], g_oob[i]}), 96'(8'hf0));
      check("wide_eol_last", 96'({g_eol[i], g_last[i]}), 96'({1'b1, i == 3}));
    end

    // Partial last beat: W=5 over four lanes
    set_cfg(8, 10, 0, 4, 5, 1, 2);
    do_start(2);
    collect(1'b0, 100);
    check("part_nbeats", 96'(nb), 96'(6));
    for (int i = 0; i < 6 && i < nb; i++) begin
      int r;
      r = 3 + i / 2;
      if (i % 2 == 0) begin
        check("part_addr0", 96'(g_addr[i]),
              96'({20'(r * 10 + 6), 20'(r * 10 + 5), 20'(r * 10 + 4), 20'(r * 10 + 3)}));
        check("part_mask0", 96'({g_mask[i], g_oob[i], g_eol[i]}), 96'({4'hf, 4'h0, 1'b0}));
      end else begin
        check("part_addr1", 96'(g_addr[i]), 96'(r * 10 + 7));
        check("part_mask1", 96'({g_mask[i], g_oob[i], g_eol[i]}), 96'({4'h1, 4'h0, 1'b1}));
      end
      check("part_last", 96'(g_last[i]), 96'(i == 5));
    end

    // Random backpressure on the basic window
    set_cfg(8, 10, 0, 4, 5, 1, 1);
    do_start(0);
    collect(1'b1, 400);
    check_basic_seq("bp");

    // Illegal configurations
    set_cfg(8, 10, 0, 4, 5, 36, 1);
    do_start(0);
    @(posedge clk); #1;
    check("illegal_half", 96'({obs_valid, obs_done, obs_err, obs_busy}), 96'(4'b0110));
    @(posedge clk); #1;
    check("illegal_pulse", 96'({obs_done, obs_err}), 96'(0));
    set_cfg(1025, 10, 0, 4, 5, 1, 1);
    do_start(0);
    @(posedge clk); #1;
    check("illegal_rows", 96'({obs_valid, obs_done, obs_err, obs_busy}), 96'(4'b0110));
    @(posedge clk); #1;

    // Reset after four beats, then restart
    set_cfg(8, 10, 0, 4, 5, 1, 1);
    do_start(0);
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_beat", 96'({obs_valid, obs_addr}), 96'({1'b1, 80'd45}));
    reset = 1'b1;
    #1;
    check("abort_outs", 96'({obs_valid, obs_eol, obs_last, obs_busy, obs_done, obs_err,
                            obs_mask, obs_oob, obs_addr}), 96'(0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort_no_done", 96'({obs_done, obs_valid}), 96'(0));
    end
    reset = 1'b0;
    set_cfg(8, 10, 0, 4, 5, 1, 1);
    do_start(0);
    collect(1'b0, 100);
    check_basic_seq("restart");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/patch_addr_gen.md
Name: patch_addr_gen

Overview:
Runtime-configurable patch address generator for the pyramidal LK datapath. It generates memory addresses for a (2*half_r+1+EXT) x (2*half_c+1+EXT) window centred on a feature point, in raster order, LANES pixels per beat. Addresses are zero-based. Out-of-image coordinates are border-clamped and flagged. It sits between the feature/pyramid-level controller and the image-memory read port, which drives out_ready.

Parameters:
MAX_DIM, 1024, maximum image rows/cols supported
MAX_HALF, 35, maximum half_r/half_c accepted
LANES, 1, addresses emitted per beat (consecutive columns)
EXT, 1, extra trailing row and column for bilinear interpolation (0 or 1)
DW, $clog2(MAX_DIM)+1, unsigned dimension width
CW, $clog2(MAX_DIM)+2, signed coordinate width
AW, $clog2(MAX_DIM*MAX_DIM), address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
start  in  1  pulse; latches configuration when IDLE
img_rows  in  DW  image height at the current pyramid level
img_cols  in  DW  image width at the current pyramid level
base_addr  in  AW  level base offset in memory
ctr_row  in  CW  signed centre row
ctr_col  in  CW  signed centre column
half_r  in  $clog2(MAX_HALF+1)  patch half-height
half_c  in  $clog2(MAX_HALF+1)  patch half-width
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse at end of patch
cfg_err  out  1  one-cycle pulse, coincident with done, on illegal configuration
out_valid  out  1  beat valid
out_ready  in  1  consumer accepts the beat
out_addr  out  LANES*AW  lane i at bits [i*AW +: AW]
out_mask  out  LANES  lane holds a real patch pixel
out_oob  out  LANES  lane coordinate was clamped
out_eol  out  1  last beat of a patch row
out_last  out  1  last beat of the patch

Behaviour:
- Reset: FSM=IDLE; busy, done, cfg_err, out_valid, out_eol and out_last are 0; out_addr, out_mask and out_oob are 0.
- FSM states: IDLE -> SETUP on start -> RUN -> FIN -> IDLE.
- start is ignored while busy.
- SETUP takes one cycle. It computes r0=ctr_row-half_r and c0=ctr_col-half_c, plus H=2*half_r+1+EXT and W=2*half_c+1+EXT.
- Illegal configuration: half_r or half_c > MAX_HALF, img_rows or img_cols = 0, or either dimension > MAX_DIM. Response: SETUP goes directly to FIN, cfg_err=done=1 for one cycle, and no beats are emitted.
- Latency: start accepted at cycle t -> first out_valid at t+2.
- RUN sweeps rows r=r0..r0+H-1. Within each row, beats cover columns c, c+1, ..., c+LANES-1 starting at c0 and stepping by LANES.
- Lane i address = base_addr + cr*img_cols + cc, computed modulo 2^AW:
  - cr = clamp(r, 0, img_rows-1)
  - cc = clamp(c+i, 0, img_cols-1)
- out_oob[i] is high when r or c+i was clamped.
- out_mask[i] = (c+i <= c0+W-1). Masked-off lanes drive address 0 and oob 0.
- out_eol is high on a row's final beat. out_last = out_eol on row r0+H-1.
- Handshake: a beat transfers when out_valid & out_ready. While out_valid & ~out_ready, all out_* signals are held stable.
- out_valid may not drop without a transfer. Back-to-back beats are issued at one per cycle while out_ready=1.
- On transfer of the out_last beat: out_valid drops next cycle, the FSM enters FIN, and done pulses in that cycle. busy drops in the same cycle as done.
- Asserting reset mid-patch aborts immediately to the reset state. No done is issued.
- Configuration inputs may change after start; the latched copies are used.
- Degenerate case half_r=half_c=0, EXT=0: a single beat with out_eol=out_last=1.
- Arithmetic: the row address component is computed incrementally. Add img_cols per row step only when the unclamped r lies in [1, img_rows-1]; otherwise the component is held. No multiplier in the RUN loop. SETUP may use a single multiply for the initial clamped row times img_cols.

Decomposition:
- Package patch_addr_pkg: FSM state enum (IDLE, SETUP, RUN, FIN) and clamp/oob helper function for a signed coordinate against a limit.
- Sub-module patch_lane_calc: combinational per-lane column clamp, oob and mask for one lane. Instantiated LANES times in a generate loop.
- The counters, row accumulator and FSM stay in patch_addr_gen.

Test Plan:
- Basic 3x3 window. Config: img 8x10, ctr (4,5), half 1/1, EXT=0, LANES=1, base 0, out_ready=1.
  - Required addrs: 34,35,36,44,45,46,54,55,56.
  - out_eol on beats 3, 6 and 9; out_last on beat 9; done one cycle after beat 9; first valid at t+2.
- Top-left corner clamp. Same config with ctr (0,0).
  - Required addrs: 0,0,1,0,0,1,10,10,11.
  - out_oob=1 on all of row 1 and on the first beat of each row; all other oob=0.
- Wide lanes with bilinear extension. LANES=4, EXT=1, half 1/1, ctr (4,5), base 100.
  - Each row takes 1 beat with mask 4'b1111.
  - Row 1 addrs: 134,135,136,137.
  - 4 beats total; out_last on beat 4.
- Partial last beat. LANES=4, half_c=2, EXT=0 (W=5).
  - Per row: 2 beats; beat 2 has mask 4'b0001 and out_eol=1.
- Backpressure and illegal configuration.
  - Toggle out_ready randomly with 50% duty: data is held stable while stalled, and the address sequence is identical to the stall-free run.
  - start with half_r=MAX_HALF+1: no out_valid, and cfg_err=done=1 at t+2.
- Reset and restart. Assert reset after 4 beats of a 3x3 patch.
  - All outputs return to 0 and no done is issued.
  - A new start afterwards yields the full, correct sequence.
